// File: rtl/mgt_01_i_writeback_arbiter.sv
// Integer writeback arbiter: one buffered result per source (ALU, MDU, LSU),
// one register-file write per cycle, with starvation-bounded fixed priority.
module mgt_01_i_writeback_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    output logic        alu_ready_o,
    input  logic        mdu_valid_i,
    input  logic [4:0]  mdu_rd_i,
    input  logic [31:0] mdu_data_i,
    output logic        mdu_ready_o,
    input  logic        lsu_valid_i,
    input  logic [4:0]  lsu_rd_i,
    input  logic [31:0] lsu_data_i,
    output logic        lsu_ready_o,
    output logic        we_o,
    output logic [4:0]  w_iaddr_o,
    output logic [31:0] wr_idata_o,
    output logic [31:0] wb_pending_o
);
    localparam int AW   = $clog2(STARVE_LIMIT + 1);
    localparam int NSRC = 3;  // index 0 = ALU, 1 = MDU, 2 = LSU (highest priority)

    logic [NSRC-1:0] in_valid;
    logic [4:0]      in_rd   [NSRC];
    logic [31:0]     in_data [NSRC];

    logic [NSRC-1:0] slot_full;
    logic [4:0]      slot_rd   [NSRC];
    logic [31:0]     slot_data [NSRC];
    logic [AW-1:0]   slot_age  [NSRC];

    logic [NSRC-1:0] starved;
    logic [NSRC-1:0] grant;
    logic [1:0]      grant_idx;
    logic [NSRC-1:0] ready;
    logic [NSRC-1:0] accept;

    logic            we_q;
    logic [4:0]      waddr_q;
    logic [31:0]     wdata_q;

    assign in_valid   = {lsu_valid_i, mdu_valid_i, alu_valid_i};
    assign in_rd[0]   = alu_rd_i;
    assign in_rd[1]   = mdu_rd_i;
    assign in_rd[2]   = lsu_rd_i;
    assign in_data[0] = alu_data_i;
    assign in_data[1] = mdu_data_i;
    assign in_data[2] = lsu_data_i;

    // Starved slots form the upper class; the highest index wins inside a class.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        for (int i = 0; i < NSRC; i++) begin
            starved[i] = slot_full[i] && (slot_age[i] == AW'(STARVE_LIMIT));
        end
        for (int i = 0; i < NSRC; i++) begin
            if ((|starved) ? starved[i] : slot_full[i]) begin
                grant     = NSRC'(1) << i;
                grant_idx = 2'(i);
            end
        end
    end

    // Ready depends only on slot state, never on the incoming valids.
    assign ready       = ~slot_full | grant;
    assign accept      = in_valid & ready;
    assign alu_ready_o = ready[0];
    assign mdu_ready_o = ready[1];
    assign lsu_ready_o = ready[2];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_full <= '0;
            for (int i = 0; i < NSRC; i++) begin
                slot_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                // NOTE: sequential state uses non-blocking assignments only.
                if (accept[i] && (in_rd[i] != 5'd0)) begin
                    slot_full[i] <= 1'b1;
                    slot_age[i]  <= '0;
                end else if (grant[i] || !slot_full[i]) begin
                    slot_full[i] <= 1'b0;
                    slot_age[i]  <= '0;
                end else if (slot_age[i] != AW'(STARVE_LIMIT)) begin
                    slot_age[i]  <= slot_age[i] + AW'(1);
                end
            end
        end
    end

    // NOTE: the slot payload needs no reset; the full bit decides whether it is meaningful.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NSRC; i++) begin
            if (accept[i] && (in_rd[i] != 5'd0)) begin
                slot_rd[i]   <= in_rd[i];
                slot_data[i] <= in_data[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= |grant;
            if (|grant) begin
                waddr_q <= slot_rd[grant_idx];
                wdata_q <= slot_data[grant_idx];
            end
        end
    end

    assign we_o       = we_q;
    assign w_iaddr_o  = waddr_q;
    assign wr_idata_o = wdata_q;

    always_comb begin
        wb_pending_o = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (slot_full[i]) begin
                wb_pending_o[slot_rd[i]] = 1'b1;
            end
        end
        if (we_q) begin
            wb_pending_o[waddr_q] = 1'b1;
        end
        wb_pending_o[0] = 1'b0;
    end

endmodule

// File: tb/tb_mgt_01_i_writeback_arbiter.sv
// Bench for the writeback arbiter: directed scenarios plus random traffic,
// every output compared each cycle against a slot-level reference model.
module tb_mgt_01_i_writeback_arbiter;
    localparam int LIMIT = 4;

    logic        clk_i;
    logic        rst_i;
    logic        drv_v [3];
    logic [4:0]  drv_r [3];
    logic [31:0] drv_d [3];
    logic        alu_ready_o, mdu_ready_o, lsu_ready_o;
    logic        we_o;
    logic [4:0]  w_iaddr_o;
    logic [31:0] wr_idata_o;
    logic [31:0] wb_pending_o;

    mgt_01_i_writeback_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alu_valid_i(drv_v[0]), .alu_rd_i(drv_r[0]), .alu_data_i(drv_d[0]), .alu_ready_o(alu_ready_o),
        .mdu_valid_i(drv_v[1]), .mdu_rd_i(drv_r[1]), .mdu_data_i(drv_d[1]), .mdu_ready_o(mdu_ready_o),
        .lsu_valid_i(drv_v[2]), .lsu_rd_i(drv_r[2]), .lsu_data_i(drv_d[2]), .lsu_ready_o(lsu_ready_o),
        .we_o(we_o), .w_iaddr_o(w_iaddr_o), .wr_idata_o(wr_idata_o), .wb_pending_o(wb_pending_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: a buffered result per source and how many times it has lost.
    logic        m_full  [3];
    logic [4:0]  m_rd    [3];
    logic [31:0] m_data  [3];
    int          m_losses[3];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_full[i] = 1'b0; m_losses[i] = 0; m_rd[i] = '0; m_data[i] = '0;
        end
        m_we = 1'b0; m_addr = '0; m_wdata = '0;
    endtask

    // Winner: a starved result outranks any unstarved one; LSU > MDU > ALU otherwise.
    function automatic int winner();
        int best = -1;
        int best_score = -1;
        for (int i = 0; i < 3; i++) begin
            int score;
            score = (m_losses[i] >= LIMIT ? 3 : 0) + i;
            if (m_full[i] && score > best_score) begin
                best = i; best_score = score;
            end
        end
        return best;
    endfunction

    function automatic logic exp_ready(input int i);
        return !m_full[i] || (winner() == i);
    endfunction

    function automatic logic [31:0] exp_pending();
        logic [31:0] p = '0;
        for (int i = 0; i < 3; i++) if (m_full[i]) p[m_rd[i]] = 1'b1;
        if (m_we) p[m_addr] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic model_step();
        int   w;
        logic xfer [3];
        w = winner();
        for (int i = 0; i < 3; i++) xfer[i] = drv_v[i] && exp_ready(i);
        m_we = (w >= 0);
        if (w >= 0) begin
            m_addr = m_rd[w]; m_wdata = m_data[w];
        end
        for (int i = 0; i < 3; i++) begin
            if (xfer[i] && drv_r[i] != 0) begin
                m_full[i] = 1'b1; m_rd[i] = drv_r[i]; m_data[i] = drv_d[i]; m_losses[i] = 0;
            end else if (w == i || !m_full[i]) begin
                m_full[i] = 1'b0; m_losses[i] = 0;
            end else if (m_losses[i] < LIMIT) begin
                m_losses[i]++;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".we"},      32'(we_o),        32'(m_we));
        check({tag, ".addr"},    32'(w_iaddr_o),   32'(m_addr));
        check({tag, ".data"},    wr_idata_o,       m_wdata);
        check({tag, ".pending"}, wb_pending_o,     exp_pending());
        check({tag, ".alu_rdy"}, 32'(alu_ready_o), 32'(exp_ready(0)));
        check({tag, ".mdu_rdy"}, 32'(mdu_ready_o), 32'(exp_ready(1)));
        check({tag, ".lsu_rdy"}, 32'(lsu_ready_o), 32'(exp_ready(2)));
    endtask

    // Called at a negedge: drive inputs, advance the model over one posedge, compare.
    task automatic cycle(input string tag, input logic [2:0] v,
                         input logic [4:0] ra, input logic [4:0] rm, input logic [4:0] rl,
                         input logic [31:0] da, input logic [31:0] dm, input logic [31:0] dl);
        drv_v[0] = v[0]; drv_v[1] = v[1]; drv_v[2] = v[2];
        drv_r[0] = ra;   drv_r[1] = rm;   drv_r[2] = rl;
        drv_d[0] = da;   drv_d[1] = dm;   drv_d[2] = dl;
        model_step();
        @(posedge clk_i);
        @(negedge clk_i);
        compare_all(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv_v[i] = 1'b0; drv_r[i] = '0; drv_d[i] = '0;
        end
        model_reset();
        #1;
        check("rst.we",      32'(we_o),   32'd0);
        check("rst.pending", wb_pending_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        compare_all("post_rst");

        // Single ALU result
        cycle("alu1.accept", 3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0);
        check("alu1.pend5_buffered", 32'(wb_pending_o[5]), 32'd1);
        idle("alu1.write");
        check("alu1.we",    32'(we_o),   32'd1);
        check("alu1.addr",  32'(w_iaddr_o), 32'd5);
        check("alu1.data",  wr_idata_o,  32'hDEADBEEF);
        check("alu1.pend5_port", 32'(wb_pending_o[5]), 32'd1);
        idle("alu1.done");
        check("alu1.pend_clear", wb_pending_o, 32'd0);

        // Three sources at once: written LSU, MDU, ALU
        cycle("tri.accept", 3'b111, 5'd3, 5'd2, 5'd1, 32'h33, 32'h22, 32'h11);
        check("tri.mdu_wait", 32'(mdu_ready_o), 32'd0);
        check("tri.alu_wait", 32'(alu_ready_o), 32'd0);
        idle("tri.w1");
        check("tri.addr1", 32'(w_iaddr_o), 32'd1);
        idle("tri.w2");
        check("tri.addr2", 32'(w_iaddr_o), 32'd2);
        idle("tri.w3");
        check("tri.addr3", 32'(w_iaddr_o), 32'd3);
        idle("tri.drain");

        // Starvation: LSU streams every cycle, ALU must get through after LIMIT losses
        cycle("starve.fill", 3'b101, 5'd7, 5'd0, 5'd8, 32'hA7, 32'h0, 32'h80);
        for (int k = 1; k <= LIMIT; k++) begin
            check("starve.lsu_rdy", 32'(lsu_ready_o), 32'd1);
            cycle("starve.lose", 3'b100, 5'd0, 5'd0, 5'(8 + k), 32'h0, 32'h0, 32'(k));
        end
        check("starve.lsu_stall", 32'(lsu_ready_o), 32'd0);
        check("starve.alu_win",   32'(alu_ready_o), 32'd1);
        cycle("starve.win", 3'b100, 5'd0, 5'd0, 5'd13, 32'h0, 32'h0, 32'h5);
        check("starve.alu_write", 32'(w_iaddr_o), 32'd7);
        check("starve.lsu_resume", 32'(lsu_ready_o), 32'd1);
        idle("starve.d1");
        idle("starve.d2");

        // rd = 0 is accepted and dropped
        cycle("rd0", 3'b111, 5'd0, 5'd0, 5'd0, 32'h1, 32'h2, 32'h3);
        check("rd0.pending", wb_pending_o, 32'd0);
        idle("rd0.after");
        check("rd0.we", 32'(we_o), 32'd0);

        // Back-to-back ALU stream
        for (int k = 0; k < 8; k++) begin
            check("b2b.alu_rdy", 32'(alu_ready_o), 32'd1);
            cycle("b2b", 3'b001, 5'(10 + k), 5'd0, 5'd0, 32'(k * 7 + 1), 32'h0, 32'h0);
            if (k > 0) check("b2b.addr", 32'(w_iaddr_o), 32'(9 + k));
        end
        idle("b2b.last");
        check("b2b.addr_last", 32'(w_iaddr_o), 32'd17);
        idle("b2b.drain");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [4:0] r [3];
            for (int i = 0; i < 3; i++)
                r[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cycle("rand", 3'($urandom), r[0], r[1], r[2], $urandom, $urandom, $urandom);
        end

        // Asynchronous reset with all slots full and a write on the port
        cycle("arst.fill", 3'b111, 5'd4, 5'd5, 5'd6, 32'h4, 32'h5, 32'h6);
        cycle("arst.fill2", 3'b111, 5'd9, 5'd10, 5'd11, 32'h9, 32'hA, 32'hB);
        check("arst.pre_we", 32'(we_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        check("arst.we",      32'(we_o),       32'd0);
        check("arst.addr",    32'(w_iaddr_o),  32'd0);
        check("arst.data",    wr_idata_o,      32'd0);
        check("arst.pending", wb_pending_o,    32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) drv_v[i] = 1'b0;
        model_reset();
        compare_all("arst.release");
        idle("arst.idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
